acc_drain_unit: RTL and testbench

Reader for the systolic module's accumulator port. After a matrix product completes, it walks `addr_acc` over all MATRIX_SIZE² accumulators in row-major order. Each value is requantized (arithmetic right shift, then signed saturation) and streamed out on a valid/ready interface. Optionally it pulses `acc_rst` to clear the array once the last beat is accepted, so the next tile can start.

---
 rtl/acc_drain_unit.sv | 206 ++++++++++++++++++++
 tb/tb_acc_drain_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_drain_unit.sv
// -----------------------------------------------------------------------------
// acc_drain_unit
//
// Streams the MATRIX_SIZE x MATRIX_SIZE accumulator array of the systolic
// module out on a valid/ready interface once a matrix product has finished.
// The accumulators are visited in row-major order through addr_acc. Each
// value is requantized by an arithmetic right shift and a signed saturation
// to OUT_WIDTH bits. When requested, a single-cycle acc_rst pulse clears the
// array after the final beat has been accepted.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        drain request, only honoured while idle
//   shift_amt    right-shift amount, captured with start
//   clear_after  request an acc_rst pulse after the last beat, captured with start
//   addr_acc     accumulator select driven to the systolic module
//   acc_in       selected accumulator value (combinational in addr_acc)
//   acc_rst      single-cycle accumulator clear request
//   m_valid      output beat valid
//   m_ready      downstream accept
//   m_data       requantized element
//   m_last       marks the beat for the final accumulator
//   busy         high whenever a drain (or its clear) is in progress
//   done         single-cycle completion pulse
// -----------------------------------------------------------------------------
module acc_drain_unit #(
  parameter int MATRIX_SIZE    = 8,
  parameter int ACC_WIDTH      = 32,
  parameter int OUT_WIDTH      = 8,
  parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE * MATRIX_SIZE),
  parameter int SHIFT_WIDTH    = $clog2(ACC_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SHIFT_WIDTH-1:0]      shift_amt,
  input  logic                        clear_after,
  output logic [ACC_ADDR_WIDTH-1:0]   addr_acc,
  input  logic signed [ACC_WIDTH-1:0] acc_in,
  output logic                        acc_rst,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [OUT_WIDTH-1:0] m_data,
  output logic                        m_last,
  output logic                        busy,
  output logic                        done
);

  localparam int NUM_ACC = MATRIX_SIZE * MATRIX_SIZE;
  localparam logic [ACC_ADDR_WIDTH-1:0] LAST_ADDR = ACC_ADDR_WIDTH'(NUM_ACC - 1);

  // Saturation bounds expressed at accumulator width so the comparison is
  // done on the full shifted value.
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  // Arithmetic right shift; truncates toward -inf, no rounding.
  function automatic logic signed [ACC_WIDTH-1:0] shift_acc(
    input logic signed [ACC_WIDTH-1:0] value,
    input logic [SHIFT_WIDTH-1:0]      amount
  );
    return value >>> amount;
  endfunction

  // Clamp a full-width signed value into the signed OUT_WIDTH range.
  function automatic logic signed [OUT_WIDTH-1:0] sat_out(
    input logic signed [ACC_WIDTH-1:0] value
  );
    logic signed [ACC_WIDTH-1:0] clamped;
    if (value > OUT_MAX) begin
      clamped = OUT_MAX;
    end else if (value < OUT_MIN) begin
      clamped = OUT_MIN;
    end else begin
      clamped = value;
    end
    return clamped[OUT_WIDTH-1:0];
  endfunction

  state_t                        state_q,   state_d;
  logic [ACC_ADDR_WIDTH-1:0]     addr_q,    addr_d;
  logic [SHIFT_WIDTH-1:0]        shift_q,   shift_d;
  logic                          clear_q,   clear_d;
  logic                          valid_q,   valid_d;
  logic signed [OUT_WIDTH-1:0]   data_q,    data_d;
  logic                          last_q,    last_d;
  logic                          done_q,    done_d;
  logic                          acc_rst_q, acc_rst_d;

  // The output register may take a new beat when it is empty or when its
  // current beat is being handed over in this same cycle.
  logic out_free;
  assign out_free = ~valid_q | m_ready;

  // ---------------------------------------------------------------------------
  // Next-state and output-register logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    shift_d   = shift_q;
    clear_d   = clear_q;
    valid_d   = valid_q;
    data_d    = data_q;
    last_d    = last_q;
    done_d    = 1'b0;
    acc_rst_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d = shift_amt;
          clear_d = clear_after;
          addr_d  = '0;
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (out_free) begin
          data_d  = sat_out(shift_acc(acc_in, shift_q));
          valid_d = 1'b1;
          last_d  = (addr_q == LAST_ADDR);
          // addr_acc stays on the final index once it has been read.
          if (addr_q == LAST_ADDR) begin
            state_d = S_FLUSH;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end

      S_FLUSH: begin
        if (valid_q && m_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (clear_q) begin
            // acc_rst is registered, so it is high for exactly the CLEAR cycle.
            acc_rst_d = 1'b1;
            state_d   = S_CLEAR;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_CLEAR: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      shift_q   <= '0;
      clear_q   <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      shift_q   <= shift_d;
      clear_q   <= clear_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_q    <= last_d;
      done_q    <= done_d;
      acc_rst_q <= acc_rst_d;
    end
  end

  assign addr_acc = addr_q;
  assign m_valid  = valid_q;
  assign m_data   = data_q;
  assign m_last   = last_q;
  assign acc_rst  = acc_rst_q;
  assign done     = done_q;
  // done is registered on the transition into IDLE, so busy drops exactly
  // when done rises.
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_acc_drain_unit.sv
module tb_acc_drain_unit;

  localparam int MS  = 8;
  localparam int AW  = 32;
  localparam int OW  = 8;
  localparam int ADW = 6;
  localparam int SW  = 5;
  localparam int N   = MS * MS;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [SW-1:0]        shift_amt;
  logic                 clear_after;
  logic [ADW-1:0]       addr_acc;
  logic signed [AW-1:0] acc_in;
  logic                 acc_rst;
  logic                 m_valid;
  logic                 m_ready;
  logic signed [OW-1:0] m_data;
  logic                 m_last;
  logic                 busy;
  logic                 done;

  logic signed [AW-1:0] acc_mem [N];
  assign acc_in = acc_mem[addr_acc];

  int tests_run    = 0;
  int tests_failed = 0;

  acc_drain_unit #(
    .MATRIX_SIZE(MS),
    .ACC_WIDTH(AW),
    .OUT_WIDTH(OW),
    .ACC_ADDR_WIDTH(ADW),
    .SHIFT_WIDTH(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .shift_amt(shift_amt),
    .clear_after(clear_after),
    .addr_acc(addr_acc),
    .acc_in(acc_in),
    .acc_rst(acc_rst),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Stimulus only: pulses start for one edge; returns at the negedge after it.
  task automatic do_start(input logic [SW-1:0] sh, input logic clr);
    @(negedge clk);
    shift_amt   = sh;
    clear_after = clr;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill_identity();
    for (int i = 0; i < N; i++) acc_mem[i] = i;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; shift_amt = '0; clear_after = 1'b0; m_ready = 1'b0;
    fill_identity();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({addr_acc, m_valid, m_data, m_last, acc_rst, busy, done} !== '0) begin
      tests_failed++;
      $display("FAIL reset_hold: addr=%0d valid=%b data=%0d last=%b acc_rst=%b busy=%b done=%b, expected all 0",
               addr_acc, m_valid, m_data, m_last, acc_rst, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({addr_acc, m_valid, m_data, m_last, acc_rst, busy, done} !== '0) begin
      tests_failed++;
      $display("FAIL reset_release: addr=%0d valid=%b data=%0d busy=%b done=%b, expected all 0",
               addr_acc, m_valid, m_data, busy, done);
    end
  endtask

  task automatic test_identity();
    fill_identity();
    m_ready = 1'b1;
    do_start(5'd0, 1'b0);
    tests_run++;
    if ({busy, m_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL identity_start_latency: busy=%b valid=%b, expected busy=1 valid=0", busy, m_valid);
    end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      tests_run++;
      if ({m_valid, m_data, m_last, done, acc_rst} !== {1'b1, OW'(i), (i == N - 1), 2'b00}) begin
        tests_failed++;
        $display("FAIL identity_beat%0d: valid=%b data=%0d last=%b done=%b acc_rst=%b, expected 1/%0d/%b/0/0",
                 i, m_valid, m_data, m_last, done, acc_rst, i, (i == N - 1));
      end
    end
    @(negedge clk);
    tests_run++;
    if ({m_valid, done, busy, acc_rst} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL identity_done: valid=%b done=%b busy=%b acc_rst=%b, expected 0/1/0/0",
               m_valid, done, busy, acc_rst);
    end
    @(negedge clk);
    tests_run++;
    if ({done, acc_rst, busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL identity_done_pulse: done=%b acc_rst=%b busy=%b, expected 0/0/0", done, acc_rst, busy);
    end
  endtask

  task automatic test_saturation();
    int exp_a [8];
    int exp_b [4];
    int w;
    exp_a = '{127, -128, 63, -33, 127, -2, 127, 125};
    exp_b = '{127, -128, -128, 127};
    for (int i = 0; i < N; i++) acc_mem[i] = '0;
    acc_mem[0] = 1000;  acc_mem[1] = -1000; acc_mem[2] = 255;  acc_mem[3] = -129;
    acc_mem[4] = 32'sh7FFF_FFFF; acc_mem[5] = -5; acc_mem[6] = 508; acc_mem[7] = 500;
    m_ready = 1'b1;
    do_start(5'd2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests_run++;
      if (m_valid !== 1'b1 || m_data !== OW'(exp_a[i])) begin
        tests_failed++;
        $display("FAIL sat_shift2_beat%0d: valid=%b data=%0d, expected 1/%0d", i, m_valid, m_data, exp_a[i]);
      end
    end
    w = 0;
    while (done !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_shift2_done_timeout: done=%b, expected 1", done);
    end
    acc_mem[0] = 255; acc_mem[1] = -129; acc_mem[2] = -128; acc_mem[3] = 127;
    do_start(5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (m_valid !== 1'b1 || m_data !== OW'(exp_b[i])) begin
        tests_failed++;
        $display("FAIL sat_shift0_beat%0d: valid=%b data=%0d, expected 1/%0d", i, m_valid, m_data, exp_b[i]);
      end
    end
    w = 0;
    while (done !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_shift0_done_timeout: done=%b, expected 1", done);
    end
  endtask

  task automatic test_backpressure();
    int idx;
    int cyc;
    int w;
    logic have_prev;
    logic [OW+ADW+1:0] prev;
    for (int i = 0; i < N; i++) acc_mem[i] = i * 3 - 90;
    m_ready = 1'b0;
    do_start(5'd0, 1'b0);
    idx = 0; cyc = 0; have_prev = 1'b0; prev = '0;
    while (idx < N && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (have_prev) begin
        tests_run++;
        if ({m_valid, m_last, m_data, addr_acc} !== prev) begin
          tests_failed++;
          $display("FAIL bp_stall_hold idx%0d: got %h, expected %h", idx, {m_valid, m_last, m_data, addr_acc}, prev);
        end
        have_prev = 1'b0;
      end
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid === 1'b1) begin
        if (m_ready) begin
          tests_run++;
          if (m_data !== OW'(idx * 3 - 90) || m_last !== (idx == N - 1)) begin
            tests_failed++;
            $display("FAIL bp_beat%0d: data=%0d last=%b, expected %0d/%b",
                     idx, m_data, m_last, idx * 3 - 90, (idx == N - 1));
          end
          idx++;
        end else begin
          prev = {m_valid, m_last, m_data, addr_acc};
          have_prev = 1'b1;
        end
      end
    end
    tests_run++;
    if (idx != N) begin
      tests_failed++;
      $display("FAIL bp_beat_count: got %0d beats, expected %0d", idx, N);
    end
    m_ready = 1'b1;
    w = 0;
    while (done !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    tests_run++;
    if (done !== 1'b1 || m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_done: done=%b valid=%b, expected 1/0", done, m_valid);
    end
  endtask

  task automatic test_clear();
    int bad;
    fill_identity();
    m_ready = 1'b1;
    do_start(5'd0, 1'b1);
    bad = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (acc_rst !== 1'b0 || done !== 1'b0 || m_data !== OW'(i)) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL clear_beats: %0d bad cycles, expected 0", bad);
    end
    @(negedge clk);
    tests_run++;
    if ({m_valid, acc_rst, done, busy} !== 4'b0101) begin
      tests_failed++;
      $display("FAIL clear_pulse: valid=%b acc_rst=%b done=%b busy=%b, expected 0/1/0/1",
               m_valid, acc_rst, done, busy);
    end
    @(negedge clk);
    tests_run++;
    if ({m_valid, acc_rst, done, busy} !== 4'b0010) begin
      tests_failed++;
      $display("FAIL clear_done: valid=%b acc_rst=%b done=%b busy=%b, expected 0/0/1/0",
               m_valid, acc_rst, done, busy);
    end
    @(negedge clk);
    tests_run++;
    if ({acc_rst, done, busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL clear_after_idle: acc_rst=%b done=%b busy=%b, expected 0/0/0", acc_rst, done, busy);
    end
  endtask

  task automatic test_reset_mid_drain();
    int bad;
    int dones;
    int w;
    fill_identity();
    m_ready = 1'b1;
    do_start(5'd0, 1'b0);
    repeat (21) @(negedge clk);
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== 8'sd20) begin
      tests_failed++;
      $display("FAIL rstmid_beat20: valid=%b data=%0d, expected 1/20", m_valid, m_data);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({addr_acc, m_valid, m_data, m_last, acc_rst, busy, done} !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_immediate: addr=%0d valid=%b data=%0d busy=%b, expected all 0",
               addr_acc, m_valid, m_data, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b0 || acc_rst !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL rstmid_quiet: %0d cycles with activity, expected 0", bad);
    end
    do_start(5'd0, 1'b0);
    bad = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b1 || m_data !== OW'(i)) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL rstmid_redrain: %0d wrong beats, expected 0", bad);
    end
    dones = 0; w = 0;
    while (w < 5) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      w++;
    end
    tests_run++;
    if (dones != 1) begin
      tests_failed++;
      $display("FAIL rstmid_redrain_done: %0d done pulses, expected 1", dones);
    end
  endtask

  task automatic test_ignored_start();
    int bad;
    fill_identity();
    m_ready = 1'b1;
    do_start(5'd0, 1'b0);
    bad = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b1 || m_data !== OW'(i) || acc_rst !== 1'b0) bad++;
      if (i == 10) begin
        start = 1'b1; shift_amt = 5'd3; clear_after = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL ignstart_beats: %0d wrong beats, expected 0", bad);
    end
    @(negedge clk);
    tests_run++;
    if ({m_valid, done, busy, acc_rst} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL ignstart_done: valid=%b done=%b busy=%b acc_rst=%b, expected 0/1/0/0",
               m_valid, done, busy, acc_rst);
    end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0 || m_valid !== 1'b0 || acc_rst !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL ignstart_no_second: %0d busy cycles, expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_saturation();
    test_backpressure();
    test_clear();
    test_reset_mid_drain();
    test_ignored_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
